// File: rtl/card_pkg.sv
// Shared card encoding, deck sizing and shoe FSM states for the blackjack datapath.
// CARD_SHOE_BURN_EN adds the BURN state used to discard the top card after a shuffle.
package card_pkg;

    localparam int CARD_W    = 8;
    localparam int DECK_SIZE = 52;
    localparam int IDX_W     = 6;
    localparam int LFSR_W    = 16;

    localparam logic [LFSR_W-1:0] LFSR_RESET = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_TAPS  = 16'hB400;

    typedef enum logic [2:0] {
        ST_EMPTY,
        ST_INIT,
        ST_SHUF,
`ifdef CARD_SHOE_BURN_EN
        ST_BURN,
`endif
        ST_IDLE
    } shoe_state_t;

    // Codes 0..51 run Hearts, Diamonds, Clubs, Spades; rank 0 is the Ace.
    function automatic logic [3:0] card_rank(input logic [IDX_W-1:0] code);
        return 4'(code % 13);
    endfunction

endpackage

// File: rtl/card_shoe_lfsr.sv
// Shuffle randomness source: 16-bit Galois LFSR with seed load and step enables.
// A zero seed is replaced by the reset value so the register can never lock up.
module shoe_lfsr #(
    parameter int SEED_W = 16,
    parameter int RND_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [SEED_W-1:0] seed,
    input  logic              step,
    output logic [RND_W-1:0]  rnd
);
    import card_pkg::*;

    logic [SEED_W-1:0] lfsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr <= SEED_W'(LFSR_RESET);
        end else if (load) begin
            lfsr <= (seed == '0) ? SEED_W'(LFSR_RESET) : seed;
        end else if (step) begin
            lfsr <= {1'b0, lfsr[SEED_W-1:1]} ^ (lfsr[0] ? SEED_W'(LFSR_TAPS) : '0);
        end
    end

    // The swap index only ever needs the top bits.
    assign rnd = lfsr[SEED_W-1 -: RND_W];

endmodule

// File: rtl/card_shoe.sv
// 52-card shoe: register deck, one-swap-per-cycle Fisher-Yates shuffle, valid/pop dealing.
// Define CARD_SHOE_BURN_EN to discard deck[0] in an extra BURN cycle after each shuffle.
module card_shoe #(
    parameter int CARD_W    = 8,
    parameter int DECK_SIZE = 52,
    parameter int SEED_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEED_W-1:0] random_seed,
    input  logic              new_random_seed,
    input  logic              shuffle,
    input  logic              card_pop,
    output logic [CARD_W-1:0] card,
    output logic              card_valid,
    output logic              busy,
    output logic              empty,
    output logic [5:0]        cards_left
);
    import card_pkg::*;

    typedef logic [DECK_SIZE-1:0][IDX_W-1:0] deck_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DECK_SIZE - 1);
    localparam logic [IDX_W-1:0] FULL_CNT = IDX_W'(DECK_SIZE);

    shoe_state_t       state, state_nxt;
    deck_t             deck, deck_nxt;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  swap_i, swap_j;
    logic [IDX_W-1:0]  rnd;
    logic              lfsr_load, lfsr_step;
    logic              pop_ok;

    function automatic deck_t identity_deck();
        deck_t d;
        for (int k = 0; k < DECK_SIZE; k++) begin
            d[k] = IDX_W'(k);
        end
        return d;
    endfunction

    // j = ((i+1) * r) >> 6 always lands in 0..i, so no rejection loop is needed.
    function automatic logic [IDX_W-1:0] swap_index(input logic [IDX_W-1:0] i,
                                                    input logic [IDX_W-1:0] r);
        logic [2*IDX_W-1:0] prod;
        prod = {{IDX_W{1'b0}}, i + IDX_W'(1)} * {{IDX_W{1'b0}}, r};
        return prod[2*IDX_W-1:IDX_W];
    endfunction

    shoe_lfsr #(
        .SEED_W (SEED_W),
        .RND_W  (IDX_W)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (lfsr_load),
        .seed (random_seed),
        .step (lfsr_step),
        .rnd  (rnd)
    );

    assign lfsr_load  = new_random_seed && ((state == ST_EMPTY) || (state == ST_IDLE));
    assign lfsr_step  = (state == ST_SHUF);
    assign swap_j     = swap_index(swap_i, rnd);
    assign card_valid = (state == ST_IDLE) && (cards_left != '0);
    assign pop_ok     = card_pop && card_valid && !shuffle;
    assign empty      = (cards_left == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        card      = '0;
        case (state)
            ST_EMPTY: state_nxt = ST_EMPTY;
            ST_INIT: begin
                busy      = 1'b1;
                state_nxt = ST_SHUF;
            end
            ST_SHUF: begin
                busy = 1'b1;
                if (swap_i == IDX_W'(1)) begin
`ifdef CARD_SHOE_BURN_EN
                    state_nxt = ST_BURN;
`else
                    state_nxt = ST_IDLE;
`endif
                end
            end
`ifdef CARD_SHOE_BURN_EN
            ST_BURN: begin
                busy      = 1'b1;
                state_nxt = ST_IDLE;
            end
`endif
            ST_IDLE: begin
                if (card_valid) begin
                    card = CARD_W'(deck[ptr]);
                end
                if (pop_ok && (cards_left == IDX_W'(1))) begin
                    state_nxt = ST_EMPTY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        // A shuffle request overrides everything, including a shuffle already running.
        if (shuffle) begin
            state_nxt = ST_INIT;
        end
    end

    always_comb begin
        deck_nxt = deck;
        if (!shuffle) begin
            if (state == ST_INIT) begin
                deck_nxt = identity_deck();
            end else if (state == ST_SHUF) begin
                deck_nxt[swap_i] = deck[swap_j];
                deck_nxt[swap_j] = deck[swap_i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            deck       <= identity_deck();
            ptr        <= '0;
            swap_i     <= '0;
            cards_left <= '0;
        end else begin
            deck <= deck_nxt;
            if (shuffle) begin
                ptr        <= '0;
                cards_left <= '0;
            end else begin
                case (state)
                    ST_INIT: begin
                        ptr    <= '0;
                        swap_i <= LAST_IDX;
                    end
                    ST_SHUF: begin
                        swap_i <= swap_i - IDX_W'(1);
`ifndef CARD_SHOE_BURN_EN
                        if (swap_i == IDX_W'(1)) begin
                            cards_left <= FULL_CNT;
                        end
`endif
                    end
`ifdef CARD_SHOE_BURN_EN
                    ST_BURN: begin
                        ptr        <= IDX_W'(1);
                        cards_left <= FULL_CNT - IDX_W'(1);
                    end
`endif
                    ST_IDLE: begin
                        if (pop_ok) begin
                            ptr        <= ptr + IDX_W'(1);
                            cards_left <= cards_left - IDX_W'(1);
                        end
                    end
                    default: ptr <= ptr;
                endcase
            end
        end
    end

endmodule
